// File: rtl/add_tag_top_unit.sv
// add_tag_top_unit: zero-latency tag-attach stage for the Loom dataflow fabric.
// Prepends the configured tag to each untagged token; valid/ready pass straight
// through once the post-reset activity flag is set.
// Optional build macro: ADD_TAG_TOP_PROTOCOL_CHECK_EN compiles in
// simulation-only handshake/data checkers.
module add_tag_top_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_data,
    input  logic [TAG_WIDTH-1:0]            t0_cfg_data
);

    localparam int unsigned OUT_WIDTH = TAG_WIDTH + DATA_WIDTH;

    logic                 r_active;
    logic [OUT_WIDTH-1:0] w_tagged;

    // Activity flag: low in reset, set on the first edge that samples rst_n high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Tag occupies the MSBs, payload passes through unmodified in the LSBs.
    assign w_tagged = {t0_cfg_data, in_data};
    assign out_data = w_tagged;

    // Handshake pass-through, gated closed until the stage is active.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        if (r_active) begin
            out_valid = in_valid;
            in_ready  = out_ready;
        end
    end

`ifdef ADD_TAG_TOP_PROTOCOL_CHECK_EN
    logic                  r_prev_stall;
    logic [DATA_WIDTH-1:0] r_prev_data;

    // Remember whether an offer was stalled at the previous edge, and its payload.
    always_ff @(posedge clk) begin
        r_prev_stall <= r_active && in_valid && !in_ready;
        r_prev_data  <= in_data;
    end

    // Protocol checkers, evaluated only while the stage is active.
    always @(posedge clk) begin
        if (r_active) begin
            if (r_prev_stall && (!in_valid || (in_data != r_prev_data))) begin
                $error("add_tag_top_unit: stalled offer withdrawn or payload changed");
            end
            if (in_valid && $isunknown(t0_cfg_data)) begin
                $error("add_tag_top_unit: t0_cfg_data has X/Z while in_valid is high");
            end
            if (out_data !== {t0_cfg_data, in_data}) begin
                $error("add_tag_top_unit: out_data does not match {tag, payload}");
            end
        end
    end
`endif

endmodule

// File: tb/tb_add_tag_top_unit.sv
// Directed, table-driven bench for add_tag_top_unit (default parameters).
module tb_add_tag_top_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 4;
    localparam int unsigned OW = DW + TW;
    localparam int unsigned NV = 12;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [TW-1:0] t0_cfg_data;

    int n_tests;
    int n_fail;

    typedef struct {
        logic          v;
        logic          r;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          exp_v;
        logic          exp_r;
        logic [OW-1:0] exp_d;
    } vec_t;

    vec_t vecs [NV];

    add_tag_top_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .t0_cfg_data(t0_cfg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_hs(input string name, input logic ev, input logic er);
        chk({name, ".out_valid"}, OW'(out_valid), OW'(ev));
        chk({name, ".in_ready"},  OW'(in_ready),  OW'(er));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Vector table: {in_valid, out_ready, in_data, tag, exp out_valid, exp in_ready, exp out_data}
        vecs[0]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 4'hA, 1'b1, 1'b1, 36'hA_DEAD_BEEF}; // tag attach
        vecs[1]  = '{1'b1, 1'b0, 32'hDEAD_BEEF, 4'hA, 1'b1, 1'b0, 36'hA_DEAD_BEEF}; // backpressure
        vecs[2]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 4'hA, 1'b1, 1'b1, 36'hA_DEAD_BEEF}; // release
        vecs[3]  = '{1'b1, 1'b1, 32'h1234_5678, 4'h0, 1'b1, 1'b1, 36'h0_1234_5678}; // live tag
        vecs[4]  = '{1'b1, 1'b1, 32'h1234_5678, 4'h5, 1'b1, 1'b1, 36'h5_1234_5678};
        vecs[5]  = '{1'b1, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 36'hF_1234_5678};
        vecs[6]  = '{1'b0, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 36'hF_1234_5678}; // idle
        vecs[7]  = '{1'b0, 1'b0, 32'h0BAD_F00D, 4'h3, 1'b0, 1'b0, 36'h3_0BAD_F00D}; // both drop
        vecs[8]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b1, 36'h0_FFFF_FFFF}; // payload all ones
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0000, 4'hF, 1'b1, 1'b1, 36'hF_0000_0000}; // tag all ones
        vecs[10] = '{1'b0, 1'b0, 32'h8000_0001, 4'h8, 1'b0, 1'b0, 36'h8_8000_0001};
        vecs[11] = '{1'b1, 1'b1, 32'h8000_0001, 4'h8, 1'b1, 1'b1, 36'h8_8000_0001}; // both rise

        // Reset held with an offer pending: handshake must stay closed.
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        in_data     = 32'hCAFE_0001;
        t0_cfg_data = 4'h7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_hs($sformatf("reset[%0d]", i), 1'b0, 1'b0);
        end
        chk("reset.out_data", out_data, 36'h7_CAFE_0001);

        // Release reset; one edge later transfers are possible.
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < int'(NV); i++) begin
            in_valid    = vecs[i].v;
            out_ready   = vecs[i].r;
            in_data     = vecs[i].data;
            t0_cfg_data = vecs[i].tag;
            #1;
            chk_hs($sformatf("vec[%0d]", i), vecs[i].exp_v, vecs[i].exp_r);
            chk($sformatf("vec[%0d].out_data", i), out_data, vecs[i].exp_d);
            @(posedge clk);
            #1;
        end

        // Mid-operation reset: outputs stay open until the edge that samples rst_n low.
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        in_data     = 32'h5555_AAAA;
        t0_cfg_data = 4'hC;
        rst_n       = 1'b0;
        #1;
        chk_hs("midrst.before_edge", 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk_hs("midrst.after_edge", 1'b0, 1'b0);
        chk("midrst.out_data", out_data, 36'hC_5555_AAAA);
        rst_n = 1'b1;
        #1;
        chk_hs("midrst.released_no_edge", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_hs("midrst.recovered", 1'b1, 1'b1);

        // Tag change while a stalled offer is held.
        out_ready   = 1'b0;
        t0_cfg_data = 4'h2;
        #1;
        chk_hs("stall_tag", 1'b1, 1'b0);
        chk("stall_tag.out_data", out_data, 36'h2_5555_AAAA);
        out_ready = 1'b1;
        #1;
        chk_hs("stall_release", 1'b1, 1'b1);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
